// File: rtl/uart_tx_sched.sv
// Two-requester byte scheduler feeding a single uart_byte_tx: per-requester FIFOs, round-robin grant, tx_done watchdog.
// Push to send_en is two edges on an idle link; reqN_ready drops when that requester's FIFO is full.
module uart_tx_sched #(
    parameter int DEPTH     = 4,
    parameter int TO_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] baud_cfg,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] data_byte,
    output logic       send_en,
    output logic [2:0] baud_set,
    input  logic       tx_done,
    input  logic       uart_state,
    output logic       byte_done,
    output logic       done_id,
    output logic       busy,
    input  logic       err_clr,
    output logic       timeout_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(TO_CYCLES + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [WW-1:0] WD_LAST  = WW'(TO_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [7:0]    mem0_q [DEPTH];
    logic [7:0]    mem1_q [DEPTH];
    logic [PW-1:0] wp0_q, wp0_d, rp0_q, rp0_d, wp1_q, wp1_d, rp1_q, rp1_d;
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    data_byte_q, data_byte_d;
    logic [2:0]    baud_set_q, baud_set_d;
    logic          send_en_q, send_en_d;
    logic          byte_done_q, byte_done_d;
    logic          done_id_q, done_id_d;
    logic          gid_q, gid_d;
    logic          rr_q, rr_d;
    logic          terr_q, terr_d;
    logic [WW-1:0] wd_q, wd_d;

    logic push0, push1, pop0, pop1, ne0, ne1, grant, win;

    assign req0_ready = (cnt0_q != FULL_CNT);
    assign req1_ready = (cnt1_q != FULL_CNT);
    assign push0 = req0_valid & req0_ready;
    assign push1 = req1_valid & req1_ready;
    assign ne0   = (cnt0_q != '0);
    assign ne1   = (cnt1_q != '0);
    assign grant = (state_q == IDLE) && !uart_state && (ne0 || ne1);
    // rr_q names the requester that wins a tie; a lone non-empty FIFO always wins
    assign win   = (ne0 && ne1) ? rr_q : !ne0;
    assign pop0  = grant && !win;
    assign pop1  = grant && win;

    assign data_byte   = data_byte_q;
    assign send_en     = send_en_q;
    assign baud_set    = baud_set_q;
    assign byte_done   = byte_done_q;
    assign done_id     = done_id_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;

    always_comb begin
        wp0_d  = push0 ? wp0_q + PW'(1) : wp0_q;
        wp1_d  = push1 ? wp1_q + PW'(1) : wp1_q;
        rp0_d  = pop0 ? rp0_q + PW'(1) : rp0_q;
        rp1_d  = pop1 ? rp1_q + PW'(1) : rp1_q;
        cnt0_d = cnt0_q + CW'(push0) - CW'(pop0);
        cnt1_d = cnt1_q + CW'(push1) - CW'(pop1);
    end

    always_comb begin
        state_d     = state_q;
        data_byte_d = data_byte_q;
        baud_set_d  = baud_set_q;
        send_en_d   = 1'b0;
        byte_done_d = 1'b0;
        done_id_d   = done_id_q;
        gid_d       = gid_q;
        rr_d        = rr_q;
        wd_d        = wd_q;
        terr_d      = err_clr ? 1'b0 : terr_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d     = SEND;
                    send_en_d   = 1'b1;
                    data_byte_d = win ? mem1_q[rp1_q] : mem0_q[rp0_q];
                    baud_set_d  = baud_cfg;
                    gid_d       = win;
                    rr_d        = !win;
                end
            end
            SEND: begin
                state_d = WAIT;
                wd_d    = '0;
            end
            WAIT: begin
                if (tx_done) begin
                    state_d     = IDLE;
                    byte_done_d = 1'b1;
                    done_id_d   = gid_q;
                end else if (wd_q == WD_LAST) begin
                    // byte is dropped; a timeout beats a same-cycle err_clr
                    state_d   = IDLE;
                    terr_d    = 1'b1;
                    done_id_d = gid_q;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push0) mem0_q[wp0_q] <= req0_data;
        if (push1) mem1_q[wp1_q] <= req1_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp0_q       <= '0;
            rp0_q       <= '0;
            wp1_q       <= '0;
            rp1_q       <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            state_q     <= IDLE;
            data_byte_q <= 8'h00;
            baud_set_q  <= 3'd0;
            send_en_q   <= 1'b0;
            byte_done_q <= 1'b0;
            done_id_q   <= 1'b0;
            gid_q       <= 1'b0;
            rr_q        <= 1'b0;
            terr_q      <= 1'b0;
            wd_q        <= '0;
        end else begin
            wp0_q       <= wp0_d;
            rp0_q       <= rp0_d;
            wp1_q       <= wp1_d;
            rp1_q       <= rp1_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
            state_q     <= state_d;
            data_byte_q <= data_byte_d;
            baud_set_q  <= baud_set_d;
            send_en_q   <= send_en_d;
            byte_done_q <= byte_done_d;
            done_id_q   <= done_id_d;
            gid_q       <= gid_d;
            rr_q        <= rr_d;
            terr_q      <= terr_d;
            wd_q        <= wd_d;
        end
    end

endmodule
